switch_led_ctrl: RTL and testbench
==================================

SWITCH_LED_CTRL -- requirements
Module: switch_led_ctrl

Interface
REQ-001 Parameter DEBOUNCE_CYCLES, default 1000000: consecutive cycles a synchronized input must differ from its filtered value before the filtered value updates (min 1).
REQ-002 Parameter TICK_DIV, default 125000000: clk cycles per counter step in count modes (min 1).
REQ-003 clk  input  1  system clock; all state on rising edge.
REQ-004 rst  input  1  reset, synchronous, active-high.
REQ-005 SWITCHES  input  4  raw slide switches, asynchronous to clk.
REQ-006 BUTTONS  input  2  raw push buttons, asynchronous to clk; [0] = mode advance, [1] = load.
REQ-007 out  output  4  LED drive, registered.
REQ-008 mode  output  2  current FSM state encoding, registered.

Function
REQ-009 Each SWITCHES and BUTTONS bit passes through a 2-flop synchronizer before any use.
REQ-010 Filtered switch/button values (sw_f, btn_f) are produced per Configuration section.
REQ-011 Button press = btn_f rising edge (btn_f=1, previous btn_f=0), a one-cycle event.
REQ-012 FSM states/encoding: PASS=0, UP=1, DOWN=2, HOLD=3.
REQ-013 BUTTONS[0] press advances PASS->UP->DOWN->HOLD->PASS; no other transitions except reset.
REQ-014 4-bit counter cnt; BUTTONS[1] press loads cnt <= sw_f in any state.
REQ-015 Tick generator counts 0..TICK_DIV-1 only in UP/DOWN, emits one-cycle tick at TICK_DIV-1 and wraps to 0; cleared to 0 in PASS/HOLD and on any mode change.
REQ-016 On tick: UP cnt <= cnt+1, DOWN cnt <= cnt-1, modulo 16 (15->0 in UP, 0->15 in DOWN).
REQ-017 Load and tick in same cycle: load wins, step discarded.
REQ-018 Mode-advance and load presses in same cycle: both take effect (mode advances, cnt loads).
REQ-019 out = sw_f in PASS; out = cnt in UP/DOWN/HOLD; registered, updates cycle after source change.
REQ-020 HOLD freezes cnt except for load.
REQ-021 Latency SWITCHES change -> out in PASS: 3 cycles without debounce; 3+DEBOUNCE_CYCLES with debounce.
REQ-022 mode output equals FSM state register directly (no extra delay).

Reset
REQ-023 rst=1 at a clk edge sets: out=0, mode=PASS, cnt=0, tick counter=0, synchronizer flops=0, sw_f=0, btn_f=0, previous btn_f=0, debounce counters=0.
REQ-024 rst overrides all events in the same cycle; reset mid-count discards count and tick progress.
REQ-025 Button held through reset release registers as one press once btn_f rises to 1.

Configuration
REQ-026 Macro SWITCH_DEBOUNCE_EN defined: per-bit filter; counter increments while synchronized bit != filtered bit, clears to 0 when equal; at DEBOUNCE_CYCLES consecutive mismatches filtered bit takes synchronized value and counter clears; width = clog2(DEBOUNCE_CYCLES+1).
REQ-027 Macro SWITCH_DEBOUNCE_EN undefined: filtered value = synchronized value; DEBOUNCE_CYCLES ignored; no filter logic synthesized.

Verification (DEBOUNCE_CYCLES=4, TICK_DIV=3, macro defined unless stated)
REQ-028 PASS, SWITCHES 0->4'b1010 held -> out=4'b1010 exactly 7 cycles later; without macro, 3 cycles later.
REQ-029 SWITCHES=4'hE, press BUTTONS[1], press BUTTONS[0] -> mode=1, out=E, then F, 0, 1 every 3 cycles (wrap 15->0).
REQ-030 In DOWN with cnt=0, wait one tick -> out=F; press BUTTONS[0] -> mode=3, out stays F for 20 cycles.
REQ-031 BUTTONS[1] glitch high 3 cycles then low -> no load, cnt unchanged; held 5 cycles -> exactly one load.
REQ-032 Both buttons pressed same cycle in UP with SWITCHES=4'h5 -> mode=2, cnt=5, no step that cycle.
REQ-033 rst asserted one cycle during UP with cnt=9 -> next cycle out=0, mode=0; recovers to PASS tracking switches.

Source files
------------

// File: rtl/switch_led_ctrl.sv
// rtl/switch_led_ctrl.sv - switch/button LED controller (pass, count up/down, hold); optional debounce via SWITCH_DEBOUNCE_EN
module switch_led_ctrl #(
    parameter int DEBOUNCE_CYCLES = 1000000,
    parameter int TICK_DIV        = 125000000
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [3:0] SWITCHES,
    input  logic [1:0] BUTTONS,
    output logic [3:0] out,
    output logic [1:0] mode
);

    typedef enum logic [1:0] {
        ST_PASS = 2'd0,
        ST_UP   = 2'd1,
        ST_DOWN = 2'd2,
        ST_HOLD = 2'd3
    } state_t;

    localparam int            TW        = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
    localparam logic [TW-1:0] TICK_LAST = TW'(TICK_DIV - 1);

    if (DEBOUNCE_CYCLES < 1 || TICK_DIV < 1) begin : g_bad_param
        $error("switch_led_ctrl: DEBOUNCE_CYCLES and TICK_DIV must both be >= 1");
    end

    // Bit layout of the synchronized/filtered vector: [5:4] buttons, [3:0] switches.
    logic [5:0] sync1_q, sync1_d;
    logic [5:0] sync2_q, sync2_d;
    logic [5:0] filt;
    logic [3:0] sw_f;
    logic [1:0] btn_f;

    // Two-flop synchronizer for every raw switch and button bit
    always_comb begin
        sync1_d = {BUTTONS, SWITCHES};
        sync2_d = sync1_q;
    end

    // Synchronizer registers
    always_ff @(posedge clk) begin
        if (rst) begin
            sync1_q <= '0;
            sync2_q <= '0;
        end else begin
            sync1_q <= sync1_d;
            sync2_q <= sync2_d;
        end
    end

`ifdef SWITCH_DEBOUNCE_EN
    localparam int            DW      = $clog2(DEBOUNCE_CYCLES + 1);
    localparam logic [DW-1:0] DB_LAST = DW'(DEBOUNCE_CYCLES - 1);

    logic [5:0]         filt_q, filt_d;
    logic [5:0][DW-1:0] db_cnt_q, db_cnt_d;

    // Per-bit filter: count consecutive mismatches, adopt the new value on the last one
    always_comb begin
        filt_d   = filt_q;
        db_cnt_d = '0;
        for (int i = 0; i < 6; i++) begin
            if (sync2_q[i] != filt_q[i]) begin
                if (db_cnt_q[i] == DB_LAST) begin
                    filt_d[i] = sync2_q[i];
                end else begin
                    db_cnt_d[i] = db_cnt_q[i] + 1'b1;
                end
            end
        end
    end

    // Filter registers
    always_ff @(posedge clk) begin
        if (rst) begin
            filt_q   <= '0;
            db_cnt_q <= '0;
        end else begin
            filt_q   <= filt_d;
            db_cnt_q <= db_cnt_d;
        end
    end

    assign filt = filt_q;
`else
    assign filt = sync2_q;
`endif

    assign sw_f  = filt[3:0];
    assign btn_f = filt[5:4];

    logic [1:0]    btn_prev_q, btn_prev_d;
    state_t        state_q, state_d;
    logic [3:0]    cnt_q, cnt_d;
    logic [3:0]    out_q, out_d;
    logic [TW-1:0] tick_cnt_q, tick_cnt_d;
    logic          adv_press;
    logic          load_press;
    logic          counting;
    logic          tick;

    // Button press detection: rising edge of the filtered button
    always_comb begin
        adv_press  = btn_f[0] & ~btn_prev_q[0];
        load_press = btn_f[1] & ~btn_prev_q[1];
        btn_prev_d = btn_f;
    end

    // Mode FSM: each advance press steps PASS -> UP -> DOWN -> HOLD -> PASS
    always_comb begin
        state_d = state_q;
        if (adv_press) begin
            case (state_q)
                ST_PASS: state_d = ST_UP;
                ST_UP:   state_d = ST_DOWN;
                ST_DOWN: state_d = ST_HOLD;
                default: state_d = ST_PASS;
            endcase
        end
    end

    // Tick generator: runs only in count modes, restarts from zero whenever the mode changes
    always_comb begin
        counting   = (state_q == ST_UP) || (state_q == ST_DOWN);
        tick       = counting && (tick_cnt_q == TICK_LAST);
        tick_cnt_d = '0;
        if (counting && !tick && !adv_press) begin
            tick_cnt_d = tick_cnt_q + 1'b1;
        end
    end

    // Counter: a load beats a coincident tick; steps wrap modulo 16
    always_comb begin
        cnt_d = cnt_q;
        if (load_press) begin
            cnt_d = sw_f;
        end else if (tick && state_q == ST_UP) begin
            cnt_d = cnt_q + 4'd1;
        end else if (tick && state_q == ST_DOWN) begin
            cnt_d = cnt_q - 4'd1;
        end
    end

    // LED source: filtered switches in PASS, the counter otherwise
    always_comb begin
        out_d = (state_q == ST_PASS) ? sw_f : cnt_q;
    end

    // Control and output registers
    always_ff @(posedge clk) begin
        if (rst) begin
            btn_prev_q <= '0;
            state_q    <= ST_PASS;
            cnt_q      <= '0;
            tick_cnt_q <= '0;
            out_q      <= '0;
        end else begin
            btn_prev_q <= btn_prev_d;
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            tick_cnt_q <= tick_cnt_d;
            out_q      <= out_d;
        end
    end

    assign out  = out_q;
    assign mode = state_q;

endmodule

// File: tb/tb_switch_led_ctrl.sv
// tb/tb_switch_led_ctrl.sv - self-checking bench for switch_led_ctrl (vector table, directed sequences, random vs model)
module tb_switch_led_ctrl;

    localparam int DB = 4;
    localparam int TD = 3;
`ifdef SWITCH_DEBOUNCE_EN
    localparam int DB_EN = 1;
`else
    localparam int DB_EN = 0;
`endif
    localparam int LAT = DB_EN ? 3 + DB : 3;

    logic       clk = 1'b0;
    logic       rst;
    logic [3:0] SWITCHES;
    logic [1:0] BUTTONS;
    logic [3:0] out;
    logic [1:0] mode;

    int n_checks = 0;
    int n_fail   = 0;

    switch_led_ctrl #(
        .DEBOUNCE_CYCLES(DB),
        .TICK_DIV(TD)
    ) dut (
        .clk(clk),
        .rst(rst),
        .SWITCHES(SWITCHES),
        .BUTTONS(BUTTONS),
        .out(out),
        .mode(mode)
    );

    always #5 clk = ~clk;

    // Reference model: delayed copies of the raw inputs, run-length filter, integer mode/count
    int m_s1 = 0, m_s2 = 0, m_f = 0, m_prev = 0;
    int m_run[6];
    int m_mode = 0, m_cnt = 0, m_tick = 0, m_out = 0;

    always @(posedge clk) begin
        int cur_f, sw_now, btn_now, press, tick_now, raw;
        raw = {BUTTONS, SWITCHES};
        if (rst) begin
            m_s1 = 0; m_s2 = 0; m_f = 0; m_prev = 0;
            m_mode = 0; m_cnt = 0; m_tick = 0; m_out = 0;
            for (int b = 0; b < 6; b++) m_run[b] = 0;
        end else begin
            cur_f    = DB_EN ? m_f : m_s2;
            sw_now   = cur_f % 16;
            btn_now  = cur_f / 16;
            press    = btn_now & ~m_prev & 3;
            tick_now = ((m_mode == 1) || (m_mode == 2)) && (m_tick == TD - 1);
            m_out    = (m_mode == 0) ? sw_now : m_cnt;
            if ((press & 2) != 0) m_cnt = sw_now;
            else if (tick_now) m_cnt = (m_mode == 1) ? (m_cnt + 1) % 16 : (m_cnt + 15) % 16;
            if ((press & 1) != 0 || m_mode == 0 || m_mode == 3) m_tick = 0;
            else m_tick = (m_tick + 1) % TD;
            if ((press & 1) != 0) m_mode = (m_mode + 1) % 4;
            m_prev = btn_now;
            if (DB_EN != 0) begin
                for (int b = 0; b < 6; b++) begin
                    if (((m_s2 >> b) & 1) != ((m_f >> b) & 1)) begin
                        m_run[b]++;
                        if (m_run[b] == DB) begin
                            m_f = m_f ^ (1 << b);
                            m_run[b] = 0;
                        end
                    end else begin
                        m_run[b] = 0;
                    end
                end
            end
            m_s2 = m_s1;
            m_s1 = raw;
        end
    end

    task automatic check(input string name, input int act, input int exp);
        n_checks++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s actual=%0d expected=%0d at %0t", name, act, exp, $time);
        end
    endtask

    task automatic step(input int n);
        for (int i = 0; i < n; i++) begin
            @(negedge clk);
            check("model_out", out, m_out);
            check("model_mode", mode, m_mode);
        end
    endtask

    task automatic wait_mode(input int target, input int bound);
        int k = 0;
        while (mode != 2'(target) && k < bound) begin
            step(1);
            k++;
        end
        check("wait_mode", mode, target);
    endtask

    task automatic press(input int idx);
        BUTTONS[idx] = 1'b1;
        step(LAT + 3);
        BUTTONS[idx] = 1'b0;
        step(LAT + 3);
    endtask

    typedef struct {
        logic       rst;
        logic [3:0] sw;
        logic [1:0] btn;
        int         cycles;
        logic [3:0] exp_out;
        logic [1:0] exp_mode;
    } vec_t;

    vec_t vecs[7];
    int   hv;
    int   sw_alt;

    initial begin
        rst      = 1'b1;
        SWITCHES = 4'h0;
        BUTTONS  = 2'b00;

        vecs[0] = '{1'b1, 4'h0, 2'b00, 3,  4'h0, 2'd0};
        vecs[1] = '{1'b1, 4'hF, 2'b11, 3,  4'h0, 2'd0};
        vecs[2] = '{1'b0, 4'hA, 2'b00, 12, 4'hA, 2'd0};
        vecs[3] = '{1'b0, 4'h3, 2'b00, 12, 4'h3, 2'd0};
        vecs[4] = '{1'b0, 4'hC, 2'b10, 12, 4'hC, 2'd0};
        vecs[5] = '{1'b0, 4'h5, 2'b00, 12, 4'h5, 2'd0};
        vecs[6] = '{1'b0, 4'h0, 2'b00, 12, 4'h0, 2'd0};

        for (int v = 0; v < 7; v++) begin
            rst      = vecs[v].rst;
            SWITCHES = vecs[v].sw;
            BUTTONS  = vecs[v].btn;
            step(vecs[v].cycles);
            check($sformatf("vec%0d_out", v), out, vecs[v].exp_out);
            check($sformatf("vec%0d_mode", v), mode, vecs[v].exp_mode);
        end

        // Switch-to-LED latency in PASS
        SWITCHES = 4'hA;
        step(LAT - 1);
        check("lat_before", out, 4'h0);
        step(1);
        check("lat_at", out, 4'hA);

        // Load E, enter UP, count E -> F -> 0 -> 1 every TD cycles
        SWITCHES = 4'hE;
        step(LAT + 3);
        press(1);
        BUTTONS[0] = 1'b1;
        wait_mode(1, 4 * LAT);
        step(1);
        check("up_start", out, 4'hE);
        step(TD);
        check("up_f", out, 4'hF);
        step(TD);
        check("up_wrap0", out, 4'h0);
        step(TD);
        check("up_1", out, 4'h1);
        BUTTONS = 2'b00;
        step(LAT + 3);

        // Both presses in UP with switches 5: DOWN, cnt 5 with no step, then decrement
        SWITCHES = 4'h5;
        step(LAT + 3);
        BUTTONS = 2'b11;
        wait_mode(2, 4 * LAT);
        step(1);
        check("both_load", out, 4'h5);
        step(TD);
        check("down_step", out, 4'h4);
        BUTTONS = 2'b00;
        step(LAT + 3);

        // Back around to UP, then enter DOWN with cnt 0 and watch 0 -> F
        SWITCHES = 4'h0;
        press(0);
        press(0);
        press(0);
        check("cycle_up", mode, 1);
        BUTTONS = 2'b11;
        wait_mode(2, 4 * LAT);
        step(1);
        check("down_zero", out, 4'h0);
        step(TD);
        check("down_wrapF", out, 4'hF);
        BUTTONS = 2'b00;
        step(LAT + 3);

        // HOLD freezes the counter
        BUTTONS[0] = 1'b1;
        wait_mode(3, 4 * LAT);
        step(1);
        hv = m_cnt;
        for (int i = 0; i < 20; i++) begin
            step(1);
            check("hold_frozen", out, hv);
        end
        BUTTONS = 2'b00;
        step(LAT + 3);

        // Load glitch rejection and single load in HOLD
        sw_alt = (hv + 8) % 16;
        SWITCHES = 4'(sw_alt);
        step(LAT + 3);
`ifdef SWITCH_DEBOUNCE_EN
        BUTTONS[1] = 1'b1;
        step(3);
        BUTTONS[1] = 1'b0;
        step(12);
        check("glitch_noload", out, hv);
`endif
        BUTTONS[1] = 1'b1;
        step(5);
        BUTTONS[1] = 1'b0;
        step(12);
        check("held_load", out, sw_alt);
        SWITCHES = 4'(hv);
        step(12);
        check("single_load", out, sw_alt);

        // Reset in UP with cnt 9
        press(0);
        check("back_pass", mode, 0);
        SWITCHES = 4'h9;
        step(LAT + 3);
        press(1);
        BUTTONS[0] = 1'b1;
        wait_mode(1, 4 * LAT);
        step(1);
        check("up_nine", out, 4'h9);
        rst     = 1'b1;
        BUTTONS = 2'b00;
        step(1);
        rst = 1'b0;
        check("rst_out", out, 4'h0);
        check("rst_mode", mode, 0);
        SWITCHES = 4'h6;
        step(LAT + 3);
        check("rec_out", out, 4'h6);
        check("rec_mode", mode, 0);
        BUTTONS[0] = 1'b1;
        wait_mode(1, 4 * LAT);
        step(1);
        check("rst_cnt_cleared", out, 4'h0);
        BUTTONS = 2'b00;
        step(LAT + 3);

        // Button held through reset release counts as exactly one press
        BUTTONS = 2'b01;
        rst     = 1'b1;
        step(3);
        rst = 1'b0;
        step(1);
        check("held_rst_mode0", mode, 0);
        wait_mode(1, 4 * LAT);
        step(30);
        check("held_one_press", mode, 1);
        BUTTONS = 2'b00;
        step(LAT + 3);

        // Random stimulus against the model
        for (int c = 0; c < 4000; c++) begin
            if ($urandom_range(0, 15) == 0) SWITCHES = 4'($urandom);
            if ($urandom_range(0, 7) == 0) BUTTONS = 2'($urandom);
            rst = ($urandom_range(0, 399) == 0);
            step(1);
        end
        rst     = 1'b0;
        BUTTONS = 2'b00;
        step(2);

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule
